button_events: RTL and testbench

Converts the debounced button and switch levels (`btn_db[4:0]`, `sw_db[2:0]`) into single-cycle command events for the clock-configuration logic. Each button press produces a one-clock pulse. UP and DOWN also auto-repeat while held. Switch changes are reported as a one-clock pulse. The block sits directly downstream of the debouncer bank and upstream of the time-setting FSM.

---
 rtl/button_events.sv | 115 +++++++++++
 tb/tb_button_events.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_events.sv
// Turns debounced button/switch levels into one-clock command events.
// UP/DOWN auto-repeat after DELAY clocks of hold, then every PERIOD clocks.
module button_events #(
  parameter int DELAY  = 75_000_000,
  parameter int PERIOD = 20_000_000,
  parameter int CW     = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn_db,
  input  logic [2:0] sw_db,
  output logic [4:0] btn_evt,
  output logic       rep_active,
  output logic [2:0] sw_q,
  output logic       sw_chg
);

  typedef enum logic [1:0] {IDLE, WAIT, REPEAT} state_t;

  localparam logic [CW-1:0] DLY_M1 = CW'(DELAY - 1);
  localparam logic [CW-1:0] PER_M1 = CW'(PERIOD - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          armed_q;
  logic [4:0]    btn_q;
  logic [4:0]    btn_evt_q, btn_evt_d;
  logic          rep_active_q, rep_active_d;
  logic          sw_chg_q, sw_chg_d;

  logic [4:0] rise;
  logic [1:0] ud, tick;
  logic       sw_diff, abort;

  always_comb begin
    rise    = btn_db & ~btn_q & {5{armed_q}};
    ud      = btn_db[1:0];
    sw_diff = (sw_db != sw_q);
    // Repeat stops if the held key drops, its partner joins, or the mode moves.
    abort   = ~ud[dir_q] | ud[~dir_q] | sw_diff;
    tick    = 2'b00;
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if ((rise[0] ^ rise[1]) && (ud[0] ^ ud[1]) && !sw_diff) begin
          state_d = WAIT;
          cnt_d   = '0;
          dir_d   = rise[1];
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DLY_M1) begin
          tick[dir_q] = 1'b1;
          cnt_d       = '0;
          state_d     = REPEAT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REPEAT: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == PER_M1) begin
          tick[dir_q] = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    btn_evt_d    = rise | {3'b000, tick};
    sw_chg_d     = armed_q & sw_diff;
    rep_active_d = (state_d == REPEAT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      armed_q      <= 1'b0;
      btn_q        <= '0;
      sw_q         <= '0;
      btn_evt_q    <= '0;
      rep_active_q <= 1'b0;
      sw_chg_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      armed_q      <= 1'b1;
      btn_q        <= btn_db;
      sw_q         <= sw_db;
      btn_evt_q    <= btn_evt_d;
      rep_active_q <= rep_active_d;
      sw_chg_q     <= sw_chg_d;
    end
  end

  assign btn_evt    = btn_evt_q;
  assign rep_active = rep_active_q;
  assign sw_chg     = sw_chg_q;

endmodule

// File: tb/tb_button_events.sv
// Bench for button_events: directed scenarios plus random holds, checked against
// an edge-index model of press events and hold-time repeat schedule.
module tb_button_events;

  localparam int DELAY  = 10;
  localparam int PERIOD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn_db;
  logic [2:0] sw_db;
  logic [4:0] btn_evt;
  logic       rep_active;
  logic [2:0] sw_q;
  logic       sw_chg;

  button_events #(.DELAY(DELAY), .PERIOD(PERIOD), .CW(8)) dut (
    .clk(clk), .reset(reset), .btn_db(btn_db), .sw_db(sw_db),
    .btn_evt(btn_evt), .rep_active(rep_active), .sw_q(sw_q), .sw_chg(sw_chg)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model state: a "session" is a held single UP/DOWN press started at edge kstart.
  int         edge_n = 0;
  bit         m_armed = 0;
  logic [4:0] m_prev_btn = '0;
  logic [2:0] m_prev_sw = '0;
  bit         m_sess = 0;
  int         m_kstart = 0;
  int         m_dir = 0;
  logic [4:0] exp_evt = '0;
  logic       exp_rep = 1'b0;
  logic [2:0] exp_swq = '0;
  logic       exp_chg = 1'b0;

  task automatic cyc(input logic [4:0] b, input logic [2:0] s, input logic r);
    logic [4:0] rise;
    logic [4:0] tk;
    int e;
    btn_db = b; sw_db = s; reset = r;
    @(posedge clk);
    if (r) begin
      m_armed = 0; m_prev_btn = '0; m_prev_sw = '0; m_sess = 0;
      exp_evt = '0; exp_rep = 0; exp_swq = '0; exp_chg = 0;
    end else begin
      rise = m_armed ? (b & ~m_prev_btn) : 5'b0;
      tk = '0;
      exp_chg = m_armed && (s != m_prev_sw);
      if (m_sess) begin
        if (!b[m_dir] || b[1-m_dir] || s != m_prev_sw) m_sess = 0;
        else begin
          e = edge_n - m_kstart;
          if (e >= DELAY && (e - DELAY) % PERIOD == 0) tk[m_dir] = 1'b1;
        end
      end else if ((rise[0] ^ rise[1]) && (b[0] ^ b[1]) && s == m_prev_sw) begin
        m_sess = 1; m_kstart = edge_n; m_dir = rise[1] ? 1 : 0;
      end
      exp_evt = rise | tk;
      exp_rep = m_sess && (edge_n - m_kstart) >= DELAY;
      exp_swq = s;
      m_prev_btn = b; m_prev_sw = s; m_armed = 1;
    end
    edge_n++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(5'b00001, 3'b100, 1'b1);
      vectors++;
      if ({btn_evt, rep_active, sw_q, sw_chg} !== 10'b0) begin
        errors++;
        $display("FAIL reset_state: got %b/%b/%b/%b want 0", btn_evt, rep_active, sw_q, sw_chg);
      end
    end
    for (int i = 0; i < 20; i++) begin
      cyc(5'b00001, 3'b100, 1'b0);
      vectors++;
      if (btn_evt !== 5'b0 || sw_chg !== 1'b0 || sw_q !== 3'b100 || rep_active !== 1'b0) begin
        errors++;
        $display("FAIL reset_release[%0d]: evt=%b chg=%b swq=%b rep=%b want 0/0/100/0",
                 i, btn_evt, sw_chg, sw_q, rep_active);
      end
    end
    cyc(5'b00000, 3'b100, 1'b0);
  endtask

  task automatic test_tap();
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cyc((i < 3) ? 5'b01000 : 5'b00000, 3'b100, 1'b0);
      vectors++;
      if (btn_evt !== exp_evt || rep_active !== 1'b0 || btn_evt[3] !== (i == 0)) begin
        errors++;
        $display("FAIL tap[%0d]: evt=%b rep=%b want evt=%b rep=0", i, btn_evt, rep_active, exp_evt);
      end
      pulses += btn_evt[3];
    end
    vectors++;
    if (pulses != 1) begin errors++; $display("FAIL tap_count: got %0d want 1", pulses); end
  endtask

  task automatic test_hold_up();
    int pulses = 0;
    int rep_cyc = 0;
    for (int i = 0; i < 33; i++) begin
      cyc((i < 30) ? 5'b00001 : 5'b00000, 3'b100, 1'b0);
      vectors++;
      if (btn_evt[0] !== (i == 0 || i == 10 || i == 14 || i == 18 || i == 22 || i == 26) ||
          rep_active !== (i >= 10 && i < 30) || btn_evt !== exp_evt || rep_active !== exp_rep) begin
        errors++;
        $display("FAIL hold_up[%0d]: evt=%b rep=%b want evt=%b rep=%b",
                 i, btn_evt, rep_active, exp_evt, exp_rep);
      end
      pulses += btn_evt[0];
      rep_cyc += rep_active;
    end
    vectors++;
    if (pulses != 6 || rep_cyc != 20) begin
      errors++;
      $display("FAIL hold_up_count: pulses=%0d rep=%0d want 6/20", pulses, rep_cyc);
    end
  endtask

  task automatic test_down_then_up();
    int p0 = 0, p1 = 0, rp = 0;
    for (int i = 0; i < 25; i++) begin
      cyc((i < 5) ? 5'b00010 : (i < 20) ? 5'b00011 : 5'b00000, 3'b100, 1'b0);
      vectors++;
      if (btn_evt !== exp_evt || rep_active !== exp_rep) begin
        errors++;
        $display("FAIL down_up[%0d]: evt=%b rep=%b want evt=%b rep=%b",
                 i, btn_evt, rep_active, exp_evt, exp_rep);
      end
      p0 += btn_evt[0]; p1 += btn_evt[1]; rp += rep_active;
    end
    vectors++;
    if (p0 != 1 || p1 != 1 || rp != 0) begin
      errors++;
      $display("FAIL down_up_count: up=%0d dn=%0d rep=%0d want 1/1/0", p0, p1, rp);
    end
  endtask

  task automatic test_sw_abort();
    int chg = 0, late = 0;
    for (int i = 0; i < 26; i++) begin
      cyc((i < 24) ? 5'b00001 : 5'b00000, (i < 15) ? 3'b100 : 3'b101, 1'b0);
      vectors++;
      if (btn_evt !== exp_evt || rep_active !== exp_rep || sw_chg !== exp_chg || sw_q !== exp_swq ||
          rep_active !== (i >= 10 && i < 15)) begin
        errors++;
        $display("FAIL sw_abort[%0d]: evt=%b rep=%b chg=%b want evt=%b rep=%b chg=%b",
                 i, btn_evt, rep_active, sw_chg, exp_evt, exp_rep, exp_chg);
      end
      chg += sw_chg;
      if (i >= 15) late += btn_evt[0];
    end
    vectors++;
    if (chg != 1 || late != 0) begin
      errors++;
      $display("FAIL sw_abort_count: chg=%0d late_evt=%0d want 1/0", chg, late);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) begin
      cyc(5'b00010, 3'b101, (i == 12 || i == 13) ? 1'b1 : 1'b0);
      vectors++;
      if (btn_evt !== exp_evt || rep_active !== exp_rep || sw_q !== exp_swq || sw_chg !== exp_chg ||
          ((i == 12 || i == 13) && {btn_evt, rep_active, sw_q, sw_chg} !== 10'b0) ||
          (i >= 12 && btn_evt !== 5'b0)) begin
        errors++;
        $display("FAIL reset_mid[%0d]: evt=%b rep=%b swq=%b chg=%b want evt=%b rep=%b swq=%b chg=%b",
                 i, btn_evt, rep_active, sw_q, sw_chg, exp_evt, exp_rep, exp_swq, exp_chg);
      end
    end
    cyc(5'b00000, 3'b101, 1'b0);
  endtask

  task automatic test_random();
    logic [4:0] b;
    logic [2:0] s = 3'b000;
    int len;
    for (int seg = 0; seg < 60; seg++) begin
      case ($urandom_range(0, 7))
        0, 1: b = 5'b00001;
        2, 3: b = 5'b00010;
        4:    b = 5'b00011;
        5:    b = 5'(1 << $urandom_range(2, 4)) | 5'($urandom_range(0, 3));
        default: b = 5'b00000;
      endcase
      if ($urandom_range(0, 5) == 0) s = 3'($urandom);
      len = $urandom_range(1, 25);
      for (int i = 0; i < len; i++) begin
        cyc(b, s, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        vectors++;
        if (btn_evt !== exp_evt || rep_active !== exp_rep || sw_q !== exp_swq || sw_chg !== exp_chg) begin
          errors++;
          $display("FAIL random[%0d.%0d]: evt=%b rep=%b swq=%b chg=%b want evt=%b rep=%b swq=%b chg=%b",
                   seg, i, btn_evt, rep_active, sw_q, sw_chg, exp_evt, exp_rep, exp_swq, exp_chg);
        end
      end
    end
  endtask

  initial begin
    btn_db = '0; sw_db = '0; reset = 1'b1;
    test_reset();
    test_tap();
    test_hold_up();
    test_down_then_up();
    test_sw_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
